// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns sized byte-addressed requests into word-addressed
// d_cache accesses, with read-modify-write for sub-word stores and load extension.
module mem_access_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  input  logic        ex_we_i,
  input  logic [1:0]  ex_size_i,
  input  logic        ex_unsigned_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cache_write_valid_o,
  output logic [31:0] cache_addr_o,
  output logic [31:0] cache_data_o,
  input  logic        cache_valid_i,
  input  logic [31:0] cache_data_i
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        bad_req;
  logic        busy;

  function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = old_word;
    case (sz)
      2'b00:   m[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   m[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {off, 3'b000};
    case (sz)
      2'b00:   r = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign bad_req = (ex_size_i == 2'b11) ||
                   (ex_size_i == 2'b01 && ex_addr_i[0]) ||
                   (ex_size_i == 2'b10 && (ex_addr_i[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          cnt_d = 8'd0;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            addr_d  = ex_addr_i;
            size_d  = ex_size_i;
            we_d    = ex_we_i;
            uns_d   = ex_unsigned_i;
            wdata_d = ex_wdata_i;
            if (ex_we_i && ex_size_i == 2'b10) begin
              word_d  = ex_wdata_i;
              state_d = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ, S_WRITE: begin
        if (cache_valid_i) begin
          cnt_d = 8'd0;
          if (state_q == S_WRITE) begin
            state_d = S_DONE;
          end else if (we_q) begin
            word_d  = merge_store(cache_data_i, wdata_q, size_q, addr_q[1:0]);
            state_d = S_WRITE;
          end else begin
            rdata_d = extract_load(cache_data_i, size_q, addr_q[1:0], uns_q);
            state_d = S_DONE;
          end
        // Timeout abandons the access; leaving WRITE drops the strobe uncommitted.
        end else if (cnt_q == 8'(WAIT_LIMIT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign busy                = (state_q == S_READ) || (state_q == S_WRITE);
  assign stall_o             = !rst_i && (busy || (state_q == S_IDLE && ex_valid_i));
  assign cache_write_valid_o = (state_q == S_WRITE);
  assign cache_addr_o        = busy ? {2'b00, addr_q[31:2]} : 32'd0;
  assign cache_data_o        = (state_q == S_WRITE) ? word_q : 32'd0;
  assign done_o              = (state_q == S_DONE);
  assign err_o               = (state_q == S_DONE) && err_q;
  assign rdata_valid_o       = (state_q == S_DONE) && !err_q && !we_q;
  assign rdata_o             = rdata_q;

endmodule
